adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It generalises the team's fixed 4-bit combinational adder to WIDTH bits.
- The carry chain is cut into STAGES equal segments, with the carry registered between segments, so the block closes timing at wide widths.
- A valid/ready handshake on both sides lets it sit in streaming datapaths (accumulators, address generators) with backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 2.
- STAGES, 4, number of pipeline segments; 1 <= STAGES <= WIDTH; WIDTH % STAGES == 0 (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add) / no-borrow (sub).
- ovf  output  1  signed overflow (only with ADDER_PIPE_OVF_EN; tied 0 otherwise).

Behaviour:
- Arithmetic, modulo 2^WIDTH:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + ~cin, i.e. a - b - cin. cout=1 means no borrow.
- Segment width SEG = WIDTH/STAGES.
  - Stage k adds bits [k*SEG +: SEG] with the carry registered from stage k-1.
  - Upper operand slices are skewed through delay registers so each segment sees its own beat's carry.
  - Lower result slices are delayed so every sum bit of a beat emerges together.
- Latency: a beat accepted at rising edge N (in_valid & in_ready) presents out_valid=1 with its result after edge N+STAGES-1, i.e. exactly STAGES register stages. No combinational path from a/b to sum.
- Throughput: one beat per cycle while out_ready=1.
- Per-stage valid bit. advance = ~out_valid | out_ready. in_ready = advance.
- Flow control:
  - When advance=0 the whole pipeline holds: all data and valid registers keep their values, and sum/cout/out_valid stay stable.
  - Bubbles (in_valid=0 on an accepted slot) propagate as valid=0. They do not collapse while advance=1.
  - Results leave in issue order. No drop, no duplicate.
- in_ready depends on out_valid and out_ready only, never on in_valid.
- Reset:
  - rst_n low asynchronously clears every valid bit, sum, cout and ovf to 0. in_ready reads 1 during and after reset.
  - Beats in flight at reset are discarded. Nothing is output for them after release.
  - First accept is possible on the first rising edge with rst_n high.
- STAGES=1: single registered adder, latency 1.
- sum/cout/ovf are don't-care for the bench when out_valid=0. RTL still holds the last value.

Optional Feature:
- Macro ADDER_PIPE_OVF_EN.
- Defined: ovf is registered alongside sum and is valid with out_valid. ovf = carry into MSB XOR carry out of MSB, computed on the effective operands (b inverted for sub).
- Undefined: no overflow logic is generated and ovf is constant 0.
- Port list is identical in both cases.

Test Plan:
1. Reset, WIDTH=16, STAGES=4: rst_n=0 -> out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1; after release first beat accepted immediately.
2. Full carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, sum=0x0000, cout=1; with ADDER_PIPE_OVF_EN, a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
3. Subtract: 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0; 0x1234-0x0234, cin=1 -> sum=0x0FFF, cout=1.
4. Streaming: 6 back-to-back beats (a=i, b=0x0100*i, i=1..6) with out_ready=1 -> 6 consecutive valid results 0x0101,0x0202..0x0606, in order, starting cycle 4.
5. Backpressure: fill pipe, hold out_ready=0 for 5 cycles -> in_ready=0, out_valid and sum stable; release -> remaining results emerge in order with no loss or duplication; include a bubble beat to check it is preserved.
6. Reset mid-operation: 3 beats in flight, pulse rst_n low between clock edges -> out_valid drops immediately (asynchronous), no stale result after release; a new beat returns a correct result with latency 4.

Source files
------------

// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand/result handshake bundle for adder_pipe.
// The master drives operands and accepts results; the slave is the adder.
`timescale 1ns/1ps
interface adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined ripple-carry adder/subtractor with valid/ready flow.
// The carry chain is cut into STAGES segments of WIDTH/STAGES bits with the
// carry registered between segments. Upper operand slices travel alongside
// their beat, and finished lower sum slices are carried forward so the whole
// result leaves the last register together.
// Optional feature: define ADDER_PIPE_OVF_EN to generate the registered
// signed-overflow flag; otherwise ovf is constant 0.
`timescale 1ns/1ps
module adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic         clk,
    input logic         rst_n,
    adder_pipe_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    // Inter-stage register count; one dummy slot keeps the arrays legal at STAGES=1.
    localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_paramCheck
        $error("adder_pipe: need WIDTH >= 2, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
    end

    // Segment adder: SEG-bit sum with carry-out in the top bit.
    function automatic logic [SEG:0] segAdd(input logic [SEG-1:0] x,
                                            input logic [SEG-1:0] y,
                                            input logic           c);
        segAdd = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
    endfunction

    logic             advance;
    logic [WIDTH-1:0] effB;
    logic             effC;
    logic             vld_p   [STAGES];
    logic [WIDTH-1:0] opA_p   [NREG];
    logic [WIDTH-1:0] opB_p   [NREG];
    logic [WIDTH-1:0] sum_p   [NREG];
    logic             carry_p [NREG];
    logic [WIDTH-1:0] sumOut;
    logic             coutOut;
    logic             ovfOut;

    // The whole pipeline moves only when the output slot is free or being drained.
    assign advance = ~vld_p[STAGES-1] | bus.out_ready;

    // Subtraction is a + ~b + ~cin, so invert b and the carry once at the entry.
    assign effB = bus.b ^ {WIDTH{bus.sub}};
    assign effC = bus.cin ^ bus.sub;

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_p[STAGES-1];
    assign bus.sum       = sumOut;
    assign bus.cout      = coutOut;
    assign bus.ovf       = ovfOut;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   segA;
        logic [SEG-1:0]   segB;
        logic             segC;
        logic             inV;
        logic [WIDTH-1:0] inS;
        logic [SEG:0]     segRes;
        logic [WIDTH-1:0] outS;

        if (k == 0) begin : g_src
            assign segA = bus.a[0 +: SEG];
            assign segB = effB[0 +: SEG];
            assign segC = effC;
            assign inV  = bus.in_valid;
            assign inS  = '0;
        end else begin : g_src
            assign segA = opA_p[k-1][k*SEG +: SEG];
            assign segB = opB_p[k-1][k*SEG +: SEG];
            assign segC = carry_p[k-1];
            assign inV  = vld_p[k-1];
            assign inS  = sum_p[k-1];
        end

        assign segRes = segAdd(segA, segB, segC);

        // Merge this segment's sum slice into the partial result of the beat.
        always_comb begin
            outS                  = inS;
            outS[k*SEG +: SEG]    = segRes[SEG-1:0];
        end

        // Per-stage valid bit; bubbles travel as 0 and hold under backpressure.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p[k] <= 1'b0;
            end else if (advance) begin
                vld_p[k] <= inV;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] fwdA;
            logic [WIDTH-1:0] fwdB;

            if (k == 0) begin : g_fwd
                assign fwdA = bus.a;
                assign fwdB = effB;
            end else begin : g_fwd
                assign fwdA = opA_p[k-1];
                assign fwdB = opB_p[k-1];
            end

            // Carry, partial sum and remaining operand bits of the beat move on together.
            always_ff @(posedge clk) begin
                if (advance) begin
                    opA_p[k]   <= fwdA;
                    opB_p[k]   <= fwdB;
                    sum_p[k]   <= outS;
                    carry_p[k] <= segRes[SEG];
                end
            end
        end else begin : g_out
            logic ovfNext;

`ifdef ADDER_PIPE_OVF_EN
            // Carry into the MSB is a ^ b ^ sum at that bit; overflow when it differs from cout.
            assign ovfNext = segA[SEG-1] ^ segB[SEG-1] ^ segRes[SEG-1] ^ segRes[SEG];
`else
            assign ovfNext = 1'b0;
`endif

            // Output register: the complete result, cleared by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sumOut  <= '0;
                    coutOut <= 1'b0;
                    ovfOut  <= 1'b0;
                end else if (advance) begin
                    sumOut  <= outS;
                    coutOut <= segRes[SEG];
                    ovfOut  <= ovfNext;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed bench for adder_pipe at WIDTH=16, STAGES=4.
// Each beat carries its hand-computed result; a monitor pops the expected
// results in order as the DUT hands them over.
`timescale 1ns/1ps
module tb_adder_pipe;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
`ifdef ADDER_PIPE_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic clk;
    logic rst_n;
    int   nCompared;
    int   nMismatched;
    exp_t expQ[$];
    exp_t popped;

    adder_pipe_if #(.WIDTH(WIDTH)) bus ();

    adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Present a beat now and wait (bounded) for the slot where it is accepted.
    task automatic putBeat(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                           input logic vs, input logic [15:0] es, input logic ec, input logic eo);
        bit done;
        exp_t e;
        done         = 0;
        bus.in_valid = 1'b1;
        bus.a        = va;
        bus.b        = vb;
        bus.cin      = vc;
        bus.sub      = vs;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.s = es;
                e.c = ec;
                e.o = eo;
                expQ.push_back(e);
                done = 1;
            end
        end
        if (!done) checkVal("acceptTimeout", 32'd0, 32'd1);
    endtask

    task automatic sendBeat(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                            input logic vs, input logic [15:0] es, input logic ec, input logic eo);
        @(posedge clk);
        #1;
        putBeat(va, vb, vc, vs, es, ec, eo);
    endtask

    task automatic sendBubble();
        bit done;
        done = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
        end
        if (!done) checkVal("bubbleTimeout", 32'd0, 32'd1);
    endtask

    // After a lone beat: result absent after 3 edges, present after the 4th.
    task automatic finishSingle(input string tag);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkVal({tag, "_onTime"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkVal({tag, "_leftover"}, 32'(expQ.size()), 32'd0);
    endtask

    // Scoreboard: every handed-over result must match the oldest outstanding beat.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
                checkVal("unexpectedResult", 32'd1, 32'd0);
            end else begin
                popped = expQ.pop_front();
                checkVal("sum", 32'(bus.sum), 32'(popped.s));
                checkVal("cout", 32'(bus.cout), 32'(popped.c));
                checkVal("ovf", 32'(bus.ovf), 32'(popped.o));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [15:0] streamA   [6] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    logic [15:0] streamB   [6] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
    logic [15:0] streamExp [6] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    logic        tailPatt  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        nCompared     = 0;
        nMismatched   = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        checkVal("rst_outValid", 32'(bus.out_valid), 32'd0);
        checkVal("rst_sum", 32'(bus.sum), 32'h0000);
        checkVal("rst_cout", 32'(bus.cout), 32'd0);
        checkVal("rst_ovf", 32'(bus.ovf), 32'd0);
        checkVal("rst_inReady", 32'(bus.in_ready), 32'd1);
        #13 rst_n = 1'b1;
        #1;
        checkVal("rstRel_inReady", 32'(bus.in_ready), 32'd1);

        // Full carry ripple, accepted on the first edge after release
        putBeat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        finishSingle("ripple");
        sendBeat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_ON);
        finishSingle("ovf");
        drain("t2");

        // Subtract
        sendBeat(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        sendBeat(16'h1234, 16'h0234, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0);
        drain("t3");

        // Streaming: six back-to-back beats
        for (int i = 0; i < 6; i++)
            sendBeat(streamA[i], streamB[i], 1'b0, 1'b0, streamExp[i], 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checkVal("streamValid", 32'(bus.out_valid), 32'(tailPatt[j]));
        end
        drain("t4");

        // Backpressure with a bubble in flight
        sendBeat(16'h1000, 16'h0001, 1'b0, 1'b0, 16'h1001, 1'b0, 1'b0);
        sendBubble();
        sendBeat(16'hF000, 16'h2000, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0);
        sendBeat(16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 16'hAAAA;
        bus.b         = 16'h5555;
        bus.cin       = 1'b1;
        bus.sub       = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkVal("hold_inReady", 32'(bus.in_ready), 32'd0);
            checkVal("hold_outValid", 32'(bus.out_valid), 32'd1);
            checkVal("hold_sum", 32'(bus.sum), 32'h1001);
            checkVal("hold_cout", 32'(bus.cout), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        putBeat(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkVal("bubbleKept", 32'(bus.out_valid), 32'd0);
        drain("t5");

        // Reset while beats are in flight
        sendBeat(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        sendBeat(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0);
        sendBeat(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0);
        sendBeat(16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkVal("preRst_outValid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        expQ.delete();
        #1;
        checkVal("midRst_outValid", 32'(bus.out_valid), 32'd0);
        checkVal("midRst_sum", 32'(bus.sum), 32'h0000);
        checkVal("midRst_cout", 32'(bus.cout), 32'd0);
        checkVal("midRst_inReady", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkVal("noStale", 32'(bus.out_valid), 32'd0);
        end
        sendBeat(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        finishSingle("postRst");
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
